shift_reg_param: RTL and testbench

Parametrised successor of the 32-bit two-party shift register used as a garbled-circuit benchmark. WIDTH, init-field width and per-cycle shift distance are configurable. Direction is still chosen by the garbler/evaluator control bits, and a mode input selects logical, arithmetic or rotate shifts. The block also tracks a saturating net-displacement counter and a sticky bit-loss flag, so sequential garbling tests can check shift history as well as register contents.

---
 rtl/shift_reg_param_if.sv | 29 ++
 rtl/shift_reg_param.sv | 123 ++++++++++++
 tb/tb_shift_reg_param.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_param_if.sv
// Command/result bundle for shift_reg_param: per-cycle shift command in,
// register contents and shift-history status out.
interface shift_reg_param_if #(
  parameter int WIDTH  = 32,
  parameter int INIT_W = 8,
  parameter int AMT_W  = 5,
  parameter int OFF_W  = 8
);
  logic              load;
  logic [INIT_W-1:0] g_init;
  logic [INIT_W-1:0] e_init;
  logic              g_input;
  logic              e_input;
  logic [1:0]        mode;
  logic [AMT_W-1:0]  amt;
  logic [WIDTH-1:0]  o;
  logic [OFF_W-1:0]  offset;
  logic              ovf;

  modport master (
    output load, g_init, e_init, g_input, e_input, mode, amt,
    input  o, offset, ovf
  );

  modport slave (
    input  load, g_init, e_init, g_input, e_input, mode, amt,
    output o, offset, ovf
  );
endinterface

// File: rtl/shift_reg_param.sv
// Parametrised two-party shift register. Garbler control alone shifts right,
// evaluator control alone shifts left; mode picks logical/arithmetic/rotate.
// Tracks a saturating signed net displacement and a sticky bit-loss flag.
module shift_reg_param #(
  parameter int WIDTH  = 32,
  parameter int INIT_W = 8,
  parameter int AMT_W  = 5,
  parameter int OFF_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  shift_reg_param_if.slave bus
);

  // Displacement limits, held one bit wider than the counter so that the
  // unsaturated sum can be compared without wrapping.
  localparam logic signed [OFF_W:0] OFF_MAX = {2'b00, {(OFF_W-1){1'b1}}};
  localparam logic signed [OFF_W:0] OFF_MIN = {2'b11, {(OFF_W-1){1'b0}}};

  logic [WIDTH-1:0]         o_r;
  logic [OFF_W-1:0]         offset_r;
  logic                     ovf_r;

  logic [WIDTH-1:0]         init_pattern_s;
  logic [WIDTH-1:0]         shifted_s;
  logic [WIDTH-1:0]         lost_mask_s;
  logic                     lost_s;
  logic                     shift_en_s;
  logic                     dir_right_s;
  logic signed [OFF_W:0]    off_ext_s;
  logic signed [OFF_W:0]    amt_ext_s;
  logic signed [OFF_W:0]    off_sum_s;
  logic [OFF_W-1:0]         off_sat_s;
  logic [WIDTH-1:0]         o_next_s;
  logic [OFF_W-1:0]         offset_next_s;
  logic                     ovf_next_s;

  // Init pattern: zero pad, a field of ones, garbler field, evaluator field.
  always_comb begin
    init_pattern_s = {WIDTH{1'b0}};
    init_pattern_s[3*INIT_W-1:0] = {{INIT_W{1'b1}}, bus.g_init, bus.e_init};
  end

  // Shift datapath: one-cycle barrel shift plus detection of discarded ones.
  always_comb begin
    shift_en_s  = (bus.g_input ^ bus.e_input) && (bus.mode != 2'b11) &&
                  (bus.amt != {AMT_W{1'b0}});
    dir_right_s = bus.g_input;
    shifted_s   = o_r;
    case ({dir_right_s, bus.mode})
      3'b100:  shifted_s = o_r >> bus.amt;
      3'b101:  shifted_s = $signed(o_r) >>> bus.amt;
      3'b110:  shifted_s = (o_r >> bus.amt) | (o_r << (WIDTH - int'(bus.amt)));
      3'b000:  shifted_s = o_r << bus.amt;
      3'b001:  shifted_s = o_r << bus.amt;
      3'b010:  shifted_s = (o_r << bus.amt) | (o_r >> (WIDTH - int'(bus.amt)));
      default: shifted_s = o_r;
    endcase
    // Bits that fall off the end: low amt bits going right, high amt going left.
    if (dir_right_s) begin
      lost_mask_s = ~({WIDTH{1'b1}} << bus.amt);
    end else begin
      lost_mask_s = ~({WIDTH{1'b1}} >> bus.amt);
    end
    lost_s = (|(o_r & lost_mask_s)) && (bus.mode != 2'b10);
  end

  // Saturating displacement: left adds amt, right subtracts, never wraps.
  always_comb begin
    off_ext_s = {offset_r[OFF_W-1], offset_r};
    amt_ext_s = {{(OFF_W+1-AMT_W){1'b0}}, bus.amt};
    if (dir_right_s) begin
      off_sum_s = off_ext_s - amt_ext_s;
    end else begin
      off_sum_s = off_ext_s + amt_ext_s;
    end
    if (off_sum_s > OFF_MAX) begin
      off_sat_s = OFF_MAX[OFF_W-1:0];
    end else if (off_sum_s < OFF_MIN) begin
      off_sat_s = OFF_MIN[OFF_W-1:0];
    end else begin
      off_sat_s = off_sum_s[OFF_W-1:0];
    end
  end

  // Next state: load beats shift, shift beats hold.
  always_comb begin
    o_next_s      = o_r;
    offset_next_s = offset_r;
    ovf_next_s    = ovf_r;
    if (bus.load) begin
      o_next_s      = init_pattern_s;
      offset_next_s = {OFF_W{1'b0}};
      ovf_next_s    = 1'b0;
    end else if (shift_en_s) begin
      o_next_s      = shifted_s;
      offset_next_s = off_sat_s;
      ovf_next_s    = ovf_r | lost_s;
    end else begin
      o_next_s      = o_r;
      offset_next_s = offset_r;
      ovf_next_s    = ovf_r;
    end
  end

  // State registers; reset reloads the live init pattern without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_r      <= init_pattern_s;
      offset_r <= {OFF_W{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      o_r      <= o_next_s;
      offset_r <= offset_next_s;
      ovf_r    <= ovf_next_s;
    end
  end

  assign bus.o      = o_r;
  assign bus.offset = offset_r;
  assign bus.ovf    = ovf_r;

endmodule

// File: tb/tb_shift_reg_param.sv
// Scoreboard bench for shift_reg_param: drivers push hand-computed expected
// results, per-instance monitors pop and compare after each clock or reset.
module tb_shift_reg_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam logic [31:0] P_A = 32'h00FF_A53C;

  shift_reg_param_if #(.WIDTH(32), .INIT_W(8), .AMT_W(5), .OFF_W(8)) bus_a ();
  shift_reg_param_if #(.WIDTH(24), .INIT_W(8), .AMT_W(4), .OFF_W(8)) bus_b ();

  shift_reg_param #(.WIDTH(32), .INIT_W(8), .AMT_W(5), .OFF_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  shift_reg_param #(.WIDTH(24), .INIT_W(8), .AMT_W(4), .OFF_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  typedef struct {
    string       name;
    logic [31:0] o;
    logic [7:0]  off;
    logic        ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic compare(input exp_t e, input logic [31:0] ao, input logic [7:0] aoff,
                         input logic aovf);
    n_cmp++;
    if (ao !== e.o || aoff !== e.off || aovf !== e.ovf) begin
      n_err++;
      $display("FAIL %s: got o=%h offset=%h ovf=%b, want o=%h offset=%h ovf=%b",
               e.name, ao, aoff, aovf, e.o, e.off, e.ovf);
    end
  endtask

  // Monitor for the 32-bit instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        compare(e, bus_a.o, bus_a.offset, bus_a.ovf);
      end
    end
  end

  // Monitor for the 24-bit instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        compare(e, {8'h00, bus_b.o}, bus_b.offset, bus_b.ovf);
      end
    end
  end

  task automatic cyc_a(input logic ld, input logic g, input logic e, input logic [1:0] md,
                       input logic [4:0] am, input string nm, input logic [31:0] eo,
                       input logic [7:0] eoff, input logic eovf);
    exp_t x;
    bus_a.load = ld; bus_a.g_input = g; bus_a.e_input = e;
    bus_a.mode = md; bus_a.amt = am;
    x.name = nm; x.o = eo; x.off = eoff; x.ovf = eovf;
    q_a.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic ld, input logic g, input logic e, input logic [1:0] md,
                       input logic [3:0] am, input string nm, input logic [31:0] eo,
                       input logic [7:0] eoff, input logic eovf);
    exp_t x;
    bus_b.load = ld; bus_b.g_input = g; bus_b.e_input = e;
    bus_b.mode = md; bus_b.amt = am;
    x.name = nm; x.o = eo; x.off = eoff; x.ovf = eovf;
    q_b.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Short reset pulse placed between clock edges; checked on the rst edge.
  task automatic pulse_rst(input string nm, input logic [31:0] eo);
    exp_t x;
    x.name = nm; x.o = eo; x.off = 8'h00; x.ovf = 1'b0;
    q_a.push_back(x);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pv;
    logic [31:0] rot_o [5];
    logic [7:0]  rot_off [5];
    logic [31:0] ar_o [6];
    logic        ar_v [6];
    int          v;

    rot_o   = '{32'h007F_D29E, 32'h003F_E94F, 32'h801F_F4A7, 32'hC00F_FA53, 32'hE007_FD29};
    rot_off = '{8'h1F, 8'h3E, 8'h5D, 8'h7C, 8'h7F};
    ar_o    = '{32'hFF_F800, 32'hFF_FF80, 32'hFF_FFF8, 32'hFF_FFFF, 32'hFF_FFFF, 32'hFF_FFFF};
    ar_v    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    bus_a.load = 1'b0; bus_a.g_input = 1'b0; bus_a.e_input = 1'b0;
    bus_a.mode = 2'b00; bus_a.amt = 5'd0;
    bus_a.g_init = 8'hA5; bus_a.e_init = 8'h3C;
    bus_b.load = 1'b0; bus_b.g_input = 1'b0; bus_b.e_input = 1'b0;
    bus_b.mode = 2'b00; bus_b.amt = 4'd0;
    bus_b.g_init = 8'h80; bus_b.e_init = 8'h00;

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset and load
    pulse_rst("rst_value", P_A);
    cyc_a(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, "idle_hold", P_A, 8'h00, 1'b0);
    bus_a.g_init = 8'h11;
    cyc_a(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, "load_g11", 32'h00FF_113C, 8'h00, 1'b0);
    bus_a.g_init = 8'hA5;
    cyc_a(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, "load_a5", P_A, 8'h00, 1'b0);

    // Logical right, then hold with both controls low
    cyc_a(1'b0, 1'b1, 1'b0, 2'b00, 5'd4, "lsr4", 32'h000F_FA53, 8'hFC, 1'b1);
    cyc_a(1'b0, 1'b0, 1'b0, 2'b00, 5'd4, "hold_both_low", 32'h000F_FA53, 8'hFC, 1'b1);

    // Rotate left and the various hold conditions
    cyc_a(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, "reload1", P_A, 8'h00, 1'b0);
    cyc_a(1'b0, 1'b0, 1'b1, 2'b10, 5'd8, "rol8", 32'hFFA5_3C00, 8'h08, 1'b0);
    cyc_a(1'b0, 1'b1, 1'b1, 2'b00, 5'd3, "both_high", 32'hFFA5_3C00, 8'h08, 1'b0);
    cyc_a(1'b0, 1'b0, 1'b1, 2'b11, 5'd3, "mode_hold", 32'hFFA5_3C00, 8'h08, 1'b0);
    cyc_a(1'b0, 1'b0, 1'b1, 2'b00, 5'd0, "amt_zero", 32'hFFA5_3C00, 8'h08, 1'b0);
    cyc_a(1'b0, 1'b0, 1'b0, 2'b01, 5'd3, "both_low_arith", 32'hFFA5_3C00, 8'h08, 1'b0);

    // Load wins over a simultaneous shift
    cyc_a(1'b1, 1'b1, 1'b0, 2'b00, 5'd4, "load_beats_shift", P_A, 8'h00, 1'b0);

    // Left shifts: lossless, lossy, arithmetic behaves as logical
    cyc_a(1'b0, 1'b0, 1'b1, 2'b00, 5'd8, "lsl8", 32'hFFA5_3C00, 8'h08, 1'b0);
    cyc_a(1'b0, 1'b0, 1'b1, 2'b00, 5'd4, "lsl4_lose", 32'hFA53_C000, 8'h0C, 1'b1);
    cyc_a(1'b0, 1'b0, 1'b1, 2'b01, 5'd4, "asl4", 32'hA53C_0000, 8'h10, 1'b1);

    // Rotate right never sets ovf
    cyc_a(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, "reload2", P_A, 8'h00, 1'b0);
    cyc_a(1'b0, 1'b1, 1'b0, 2'b10, 5'd4, "ror4", 32'hC00F_FA53, 8'hFC, 1'b0);

    // Negative saturation with logical right shifts
    cyc_a(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, "reload3", P_A, 8'h00, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      pv = P_A;
      v = -4 * k;
      if (v < -128) v = -128;
      cyc_a(1'b0, 1'b1, 1'b0, 2'b00, 5'd4, $sformatf("sat_lsr_%0d", k),
            pv >> (4 * k), 8'(v), 1'b1);
    end
    cyc_a(1'b0, 1'b0, 1'b1, 2'b00, 5'd1, "sat_then_left", 32'h0, 8'h81, 1'b0 | 1'b1);

    // Positive saturation with rotate-left by 31
    cyc_a(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, "reload4", P_A, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc_a(1'b0, 1'b0, 1'b1, 2'b10, 5'd31, $sformatf("sat_rol31_%0d", k),
            rot_o[k], rot_off[k], 1'b0);
    end

    // Async reset in the middle of a right-shift stream
    cyc_a(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, "reload5", P_A, 8'h00, 1'b0);
    cyc_a(1'b0, 1'b1, 1'b0, 2'b00, 5'd1, "stream_1", 32'h007F_D29E, 8'hFF, 1'b0);
    cyc_a(1'b0, 1'b1, 1'b0, 2'b00, 5'd1, "stream_2", 32'h003F_E94F, 8'hFE, 1'b0);
    pulse_rst("async_rst", P_A);
    cyc_a(1'b0, 1'b1, 1'b0, 2'b00, 5'd1, "first_after_rst", 32'h007F_D29E, 8'hFF, 1'b0);
    cyc_a(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, "idle_end", 32'h007F_D29E, 8'hFF, 1'b0);

    // 24-bit instance: arithmetic right with sign fill
    cyc_b(1'b1, 1'b0, 1'b0, 2'b00, 4'd0, "b_load", 32'h00FF_8000, 8'h00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc_b(1'b0, 1'b1, 1'b0, 2'b01, 4'd4, $sformatf("b_asr_%0d", k),
            ar_o[k], 8'(-4 * (k + 1)), ar_v[k]);
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending a=%0d b=%0d, want 0", q_a.size(), q_b.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
